// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full adder is reused LSB-first over WIDTH clocks,
// with operands in and the result out over valid/ready handshakes.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a, op_b, acc, acc_nxt;
    logic             carry;
    logic             fa_s, fa_c;
    logic             accept, last;

    full_adder u_fa (
        .a    (op_a[cnt]),
        .b    (op_b[cnt]),
        .cin  (carry),
        .sum  (fa_s),
        .cout (fa_c)
    );

    assign accept = in_valid && (state == IDLE);
    assign last   = (cnt == CW'(WIDTH - 1));

    // Partial result with the current bit merged in; becomes the visible sum on the last bit.
    always_comb begin
        acc_nxt      = acc;
        acc_nxt[cnt] = fa_s;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is folded in at capture time as A + ~B + 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            acc   <= acc_nxt;
            carry <= fa_c;
            if (last) begin
                sum  <= acc_nxt;
                cout <= fa_c;
                ovf  <= carry ^ fa_c;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed and random operations on an 8-bit and a 2-bit instance,
// checked against an arithmetic reference model.

module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       rst;

    logic       iv8, ir8, cin8, sub8, ov8, or8, co8, of8, bz8;
    logic [7:0] a8, b8, s8;
    logic       iv2, ir2, cin2, sub2, ov2, or2, co2, of2, bz2;
    logic [1:0] a2, b2, s2;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
        .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8), .busy(bz8)
    );

    serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .cin(cin2),
        .sub(sub2), .out_valid(ov2), .out_ready(or2), .sum(s2), .cout(co2), .ovf(of2), .busy(bz2)
    );

    // Reference: A + B + cin or A - B (two's complement), width w; ovf from carry into/out of MSB.
    function automatic void model(input int w, input int unsigned x, y, input bit c, s,
                                  output int unsigned rs, output bit rc, ro);
        int unsigned mask, hmask, yy, c0, tot, cm;
        mask  = (1 << w) - 1;
        hmask = (1 << (w - 1)) - 1;
        yy    = s ? (~y & mask) : (y & mask);
        c0    = s ? 1 : int'(c);
        tot   = (x & mask) + yy + c0;
        rs    = tot & mask;
        rc    = bit'((tot >> w) & 1);
        cm    = ((x & hmask) + (yy & hmask) + c0) >> (w - 1);
        ro    = bit'(cm & 1) ^ rc;
    endfunction

    // Runs one operation on the 8-bit instance; starts and ends 1 time unit after a rising edge.
    task automatic op8(input logic [7:0] ta, tb_, input logic tc, ts,
                       output logic [7:0] rs, output logic rc, ro, output int lat, rdy_hi);
        a8 = ta; b8 = tb_; cin8 = tc; sub8 = ts; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
        lat = 0; rdy_hi = 0;
        while (!ov8 && lat < 50) begin
            if (ir8) rdy_hi++;
            @(posedge clk); #1;
            lat++;
        end
        if (ir8) rdy_hi++;
        rs = s8; rc = co8; ro = of8;
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
    endtask

    task automatic op2(input logic [1:0] ta, tb_, input logic tc, ts,
                       output logic [1:0] rs, output logic rc, ro, output int lat);
        a2 = ta; b2 = tb_; cin2 = tc; sub2 = ts; iv2 = 1'b1;
        @(posedge clk); #1;
        iv2 = 1'b0;
        lat = 0;
        while (!ov2 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rs = s2; rc = co2; ro = of2;
        or2 = 1'b1;
        @(posedge clk); #1;
        or2 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        iv8 = 0; a8 = '0; b8 = '0; cin8 = 0; sub8 = 0; or8 = 0;
        iv2 = 0; a2 = '0; b2 = '0; cin2 = 0; sub2 = 0; or2 = 0;
        repeat (2) @(posedge clk);
        #1;
        n_tot++; if ({ir8, ov8, bz8, co8, of8} !== 5'b10000) $display("FAIL reset8_ctl: got %b want 10000", {ir8, ov8, bz8, co8, of8}); else n_pass++;
        n_tot++; if (s8 !== 8'h00) $display("FAIL reset8_sum: got %h want 00", s8); else n_pass++;
        n_tot++; if ({ir2, ov2, bz2, co2, of2, s2} !== 7'b1000000) $display("FAIL reset2: got %b want 1000000", {ir2, ov2, bz2, co2, of2, s2}); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_add();
        logic [7:0] rs; logic rc, ro; int lat, rh;
        op8(8'h0F, 8'h01, 1'b0, 1'b0, rs, rc, ro, lat, rh);
        n_tot++; if ({rs, rc, ro} !== {8'h10, 2'b00}) $display("FAIL add_0f_01: got %h/%b/%b want 10/0/0", rs, rc, ro); else n_pass++;
        n_tot++; if (lat !== 8) $display("FAIL add_latency: got %0d want 8", lat); else n_pass++;
        n_tot++; if (rh !== 0) $display("FAIL add_in_ready_low: got %0d high samples want 0", rh); else n_pass++;
        n_tot++; if ({ov8, ir8, bz8} !== 3'b010) $display("FAIL add_consumed: got %b want 010", {ov8, ir8, bz8}); else n_pass++;
        op8(8'hFF, 8'h00, 1'b1, 1'b0, rs, rc, ro, lat, rh);
        n_tot++; if ({rs, rc, ro} !== {8'h00, 2'b10}) $display("FAIL add_ff_00_c1: got %h/%b/%b want 00/1/0", rs, rc, ro); else n_pass++;
        op8(8'h7F, 8'h01, 1'b0, 1'b0, rs, rc, ro, lat, rh);
        n_tot++; if ({rs, rc, ro} !== {8'h80, 2'b01}) $display("FAIL add_7f_01: got %h/%b/%b want 80/0/1", rs, rc, ro); else n_pass++;
    endtask

    task automatic test_sub();
        logic [7:0] rs; logic rc, ro; int lat, rh;
        op8(8'h05, 8'h07, 1'b1, 1'b1, rs, rc, ro, lat, rh);
        n_tot++; if ({rs, rc} !== {8'hFE, 1'b0}) $display("FAIL sub_05_07: got %h/%b want fe/0", rs, rc); else n_pass++;
        op8(8'h80, 8'h01, 1'b0, 1'b1, rs, rc, ro, lat, rh);
        n_tot++; if ({rs, rc, ro} !== {8'h7F, 2'b11}) $display("FAIL sub_80_01: got %h/%b/%b want 7f/1/1", rs, rc, ro); else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] ta, tb_, rs; logic tc, ts, rc, ro; int lat, rh;
        int unsigned es; bit ec, eo;
        for (int i = 0; i < 24; i++) begin
            ta = 8'($urandom); tb_ = 8'($urandom); tc = 1'($urandom); ts = 1'($urandom);
            model(8, ta, tb_, tc, ts, es, ec, eo);
            op8(ta, tb_, tc, ts, rs, rc, ro, lat, rh);
            n_tot++;
            if ({rs, rc, ro} !== {es[7:0], ec, eo} || lat != 8)
                $display("FAIL random_%0d a=%h b=%h cin=%b sub=%b: got %h/%b/%b lat %0d want %h/%b/%b lat 8",
                         i, ta, tb_, tc, ts, rs, rc, ro, lat, es[7:0], ec, eo);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int unsigned es; bit ec, eo; int t;
        model(8, 8'h3C, 8'h55, 1'b0, 1'b0, es, ec, eo);
        a8 = 8'h3C; b8 = 8'h55; cin8 = 0; sub8 = 0; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        t = 0;
        while (!ov8 && t < 50) begin @(posedge clk); #1; t++; end
        n_tot++; if (!ov8) $display("FAIL bp_wait: out_valid never rose"); else n_pass++;
        iv8 = 1'b1; a8 = 8'hAA; b8 = 8'h11; sub8 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_tot++;
            if ({ov8, ir8, s8, co8, of8} !== {2'b10, es[7:0], ec, eo})
                $display("FAIL bp_hold_%0d: got v%b r%b %h/%b/%b want v1 r0 %h/%b/%b", i, ov8, ir8, s8, co8, of8, es[7:0], ec, eo);
            else n_pass++;
        end
        or8 = 1'b1;
        @(posedge clk); #1;
        n_tot++; if ({ov8, ir8} !== 2'b01) $display("FAIL bp_release: got v%b r%b want v0 r1", ov8, ir8); else n_pass++;
        iv8 = 1'b0; or8 = 1'b0;
        @(posedge clk); #1;
        n_tot++; if ({ir8, bz8} !== 2'b10) $display("FAIL bp_no_accept: got r%b busy%b want r1 busy0", ir8, bz8); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] rs; logic rc, ro; int lat, rh; int seen;
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1; sub8 = 0; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b1; or8 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; or8 = 1'b0;
        n_tot++; if ({ir8, ov8, bz8, co8, of8} !== 5'b10000) $display("FAIL midrst_ctl: got %b want 10000", {ir8, ov8, bz8, co8, of8}); else n_pass++;
        n_tot++; if (s8 !== 8'h00) $display("FAIL midrst_sum: got %h want 00", s8); else n_pass++;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (ov8) seen++;
            @(posedge clk); #1;
        end
        n_tot++; if (seen !== 0) $display("FAIL midrst_no_valid: got %0d valid cycles want 0", seen); else n_pass++;
        op8(8'h12, 8'h34, 1'b0, 1'b0, rs, rc, ro, lat, rh);
        n_tot++; if ({rs, rc, ro} !== {8'h46, 2'b00}) $display("FAIL midrst_after: got %h/%b/%b want 46/0/0", rs, rc, ro); else n_pass++;
    endtask

    task automatic test_width2_exhaustive();
        logic [1:0] rs; logic rc, ro; int lat;
        int unsigned es; bit ec, eo;
        logic [4:0] v;
        for (int i = 0; i < 32; i++) begin
            v = 5'(i);
            model(2, v[4:3], v[2:1], v[0], v[0] ? 1'b0 : 1'b0, es, ec, eo);
            if (i >= 16) model(2, v[3:2], v[1:0], 1'b0, 1'b1, es, ec, eo);
            else         model(2, v[3:2], v[1:0], v[4], 1'b0, es, ec, eo);
            op2(v[3:2], v[1:0], v[4], i >= 16, rs, rc, ro, lat);
            n_tot++;
            if ({rs, rc, ro} !== {es[1:0], ec, eo} || lat != 2)
                $display("FAIL w2_%0d a=%0d b=%0d: got %0d/%b/%b lat %0d want %0d/%b/%b lat 2",
                         i, v[3:2], v[1:0], rs, rc, ro, lat, es[1:0], ec, eo);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int acc_cyc[$]; int bad;
        a2 = 2'd1; b2 = 2'd2; cin2 = 0; sub2 = 0; iv2 = 1'b1; or2 = 1'b1;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (iv2 && ir2) acc_cyc.push_back(c);
            if (ov2 && s2 !== 2'd3) bad++;
            @(posedge clk); #1;
        end
        iv2 = 1'b0; or2 = 1'b0;
        n_tot++; if (acc_cyc.size() != 10) $display("FAIL b2b_count: got %0d accepts want 10", acc_cyc.size()); else n_pass++;
        for (int i = 1; i < acc_cyc.size(); i++) begin
            n_tot++;
            if (acc_cyc[i] - acc_cyc[i-1] != 4) $display("FAIL b2b_gap_%0d: got %0d want 4", i, acc_cyc[i] - acc_cyc[i-1]);
            else n_pass++;
        end
        n_tot++; if (bad != 0) $display("FAIL b2b_sum: got %0d wrong results want 0", bad); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_width2_exhaustive();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
